// File: rtl/proc_pkg.sv
// proc_pkg: definitions shared by the processor stack blocks.
//   STK_* : stack operation codes, encoded as {pop, push}, for the control FSM
//   PROC_DATA_W : default word width, matching the R0..R7 bus width
package proc_pkg;

  localparam logic [1:0] STK_NOP  = 2'b00;
  localparam logic [1:0] STK_PUSH = 2'b01;
  localparam logic [1:0] STK_POP  = 2'b10;
  localparam logic [1:0] STK_REPL = 2'b11;

  localparam int PROC_DATA_W = 16;

endpackage : proc_pkg

// File: rtl/proc_stack_mem.sv
// proc_stack_mem: DEPTH x DATA_W register array backing the stack.
//   clk      : write clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : asynchronous read address
//   rdata_o  : asynchronous read data
// The array has no reset; entries are only meaningful below the occupancy count.
module proc_stack_mem #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Synchronous write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end else begin
      mem_q[waddr_i] <= mem_q[waddr_i];
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : proc_stack_mem

// File: rtl/proc_stack_unit.sv
// proc_stack_unit: parametrised PUSH/POP stack with a registered top of stack.
//   clk       : system clock
//   rst       : synchronous active-low reset
//   push/pop  : stack operations; both together replace the top entry
//   clear     : empty the stack, keeping the error flags
//   err_clr   : clear the sticky overflow/underflow flags
//   din       : data to push
//   top       : registered top of stack, 0 when empty
//   count     : number of valid entries, 0..DEPTH
//   empty     : count == 0
//   full      : count == DEPTH
//   overflow  : sticky, a push was rejected on a full stack
//   underflow : sticky, a pop was rejected on an empty stack
module proc_stack_unit
  import proc_pkg::*;
#(
  parameter int DATA_W = PROC_DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  logic                   err_clr,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      top,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int AW    = $clog2(DEPTH);

  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] top_q, top_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              ovf_set_s, udf_set_s;
  logic              empty_s, full_s;
  logic              we_s;
  logic [AW-1:0]     waddr_s;
  logic [AW-1:0]     raddr_s;
  logic [DATA_W-1:0] rdata_s;

  assign empty_s = (count_q == {CNT_W{1'b0}});
  assign full_s  = (count_q == CNT_W'(DEPTH));

  // The entry just below the current top, which becomes the new top on a pop.
  assign raddr_s = AW'(count_q - CNT_W'(2));

  proc_stack_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (we_s),
    .waddr_i (waddr_s),
    .wdata_i (din),
    .raddr_i (raddr_s),
    .rdata_o (rdata_s)
  );

  // Operation decode: next count/top, memory write and error events.
  always_comb begin
    count_d   = count_q;
    top_d     = top_q;
    we_s      = 1'b0;
    waddr_s   = AW'(count_q);
    ovf_set_s = 1'b0;
    udf_set_s = 1'b0;
    if (clear) begin
      count_d = {CNT_W{1'b0}};
      top_d   = {DATA_W{1'b0}};
    end else begin
      case ({pop, push})
        STK_PUSH: begin
          if (full_s) begin
            ovf_set_s = 1'b1;
          end else begin
            we_s    = 1'b1;
            waddr_s = AW'(count_q);
            count_d = count_q + CNT_W'(1);
            top_d   = din;
          end
        end
        STK_POP: begin
          if (empty_s) begin
            udf_set_s = 1'b1;
          end else if (count_q == CNT_W'(1)) begin
            count_d = {CNT_W{1'b0}};
            top_d   = {DATA_W{1'b0}};
          end else begin
            count_d = count_q - CNT_W'(1);
            top_d   = rdata_s;
          end
        end
        STK_REPL: begin
          // Replace-top overwrites the live top entry; on an empty stack it is a no-op.
          if (!empty_s) begin
            we_s    = 1'b1;
            waddr_s = AW'(count_q - CNT_W'(1));
            top_d   = din;
          end else begin
            top_d   = top_q;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
    // A newly raised error wins over err_clr in the same cycle.
    ovf_d = ovf_set_s | (ovf_q & ~err_clr);
    udf_d = udf_set_s | (udf_q & ~err_clr);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= {CNT_W{1'b0}};
      top_q   <= {DATA_W{1'b0}};
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  assign top       = top_q;
  assign count     = count_q;
  assign empty     = empty_s;
  assign full      = full_s;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule : proc_stack_unit
